adc_sequencer: RTL and testbench

Timing controller for one `adc` instance. On a start request it generates the `seq_init`, `seq_samp`, `seq_comp` and `seq_update` phase strobes for one complete SAR conversion of Madc comparison cycles. It captures `comp_out` at the end of each comparison and assembles the result word MSB-first. It sits between the readout/control logic and the `adc` sequencing inputs; the enable (`en_*`) and DAC state inputs of the `adc` are driven elsewhere.

---
 rtl/adc_sequencer.sv | 152 +++++++++++++++
 tb/tb_adc_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sequencer.sv
// SAR conversion timing controller: generates init/sample/compare/update strobes
// for one adc instance and assembles the comparator decisions MSB-first.
module adc_sequencer #(
  parameter int Madc   = 17,
  parameter int T_INIT = 1,
  parameter int T_SAMP = 4,
  parameter int T_COMP = 2,
  parameter int T_UPD  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            continuous,
  input  logic            abort,
  input  logic            comp_out,
  output logic            seq_init,
  output logic            seq_samp,
  output logic            seq_comp,
  output logic            seq_update,
  output logic            busy,
  output logic [Madc-1:0] result,
  output logic            result_valid
);

  // state | meaning
  // IDLE  | waiting for start, strobes low
  // INIT  | seq_init high for T_INIT cycles
  // SAMP  | seq_samp high for T_SAMP cycles
  // COMP  | seq_comp high for T_COMP cycles, comp_out captured on last cycle
  // UPD   | seq_update high for T_UPD cycles, then next bit
  // DONE  | result published, result_valid high for one cycle

  localparam int T_MAX01 = (T_INIT > T_SAMP) ? T_INIT : T_SAMP;
  localparam int T_MAX23 = (T_COMP > T_UPD) ? T_COMP : T_UPD;
  localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
  localparam int PW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int BW      = (Madc > 1) ? $clog2(Madc) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SAMP, S_COMP, S_UPD, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     pc, pc_nxt;
  logic [BW-1:0]     bc, bc_nxt;
  logic [Madc-1:0]   shift, shift_nxt;
  logic [BW-1:0]     bit_idx;
  logic              pc_last;

  assign bit_idx = BW'(Madc - 1) - bc;

  always_comb begin
    pc_last = 1'b0;
    case (state)
      S_INIT:  pc_last = (pc == PW'(T_INIT - 1));
      S_SAMP:  pc_last = (pc == PW'(T_SAMP - 1));
      S_COMP:  pc_last = (pc == PW'(T_COMP - 1));
      S_UPD:   pc_last = (pc == PW'(T_UPD - 1));
      default: pc_last = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc + PW'(1);
    bc_nxt    = bc;
    shift_nxt = shift;
    case (state)
      S_IDLE: begin
        pc_nxt = '0;
        bc_nxt = '0;
        if (start) state_nxt = S_INIT;
      end
      S_INIT: begin
        if (pc_last) begin
          pc_nxt    = '0;
          state_nxt = S_SAMP;
        end
      end
      S_SAMP: begin
        if (pc_last) begin
          pc_nxt    = '0;
          state_nxt = S_COMP;
        end
      end
      S_COMP: begin
        if (pc_last) begin
          pc_nxt             = '0;
          shift_nxt[bit_idx] = comp_out;
          state_nxt          = (bc == BW'(Madc - 1)) ? S_DONE : S_UPD;
        end
      end
      S_UPD: begin
        if (pc_last) begin
          pc_nxt    = '0;
          bc_nxt    = bc + BW'(1);
          state_nxt = S_COMP;
        end
      end
      S_DONE: begin
        pc_nxt    = '0;
        bc_nxt    = '0;
        shift_nxt = '0;
        state_nxt = continuous ? S_INIT : S_IDLE;
      end
      default: begin
        pc_nxt    = '0;
        bc_nxt    = '0;
        shift_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase

    // abort in DONE only cancels the restart; that cycle's result_valid is already out
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      pc_nxt    = '0;
      bc_nxt    = '0;
      shift_nxt = '0;
    end
  end

  // outputs are registered decodes of the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      bc           <= '0;
      shift        <= '0;
      seq_init     <= 1'b0;
      seq_samp     <= 1'b0;
      seq_comp     <= 1'b0;
      seq_update   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      bc           <= bc_nxt;
      shift        <= shift_nxt;
      seq_init     <= (state_nxt == S_INIT);
      seq_samp     <= (state_nxt == S_SAMP);
      seq_comp     <= (state_nxt == S_COMP);
      seq_update   <= (state_nxt == S_UPD);
      busy         <= (state_nxt != S_IDLE);
      result_valid <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) result <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: default instance plus a small override
// instance (Madc=5, T_SAMP=1, T_COMP=3, T_UPD=2).
module tb_adc_sequencer;

  logic clk = 1'b0;
  logic rst, start, continuous, abort, comp_out;
  logic seq_init, seq_samp, seq_comp, seq_update, busy, result_valid;
  logic [16:0] result;

  logic start2, comp2;
  logic s2_init, s2_samp, s2_comp, s2_upd, s2_busy, s2_valid;
  logic [4:0] s2_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .comp_out(comp_out), .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp),
    .seq_update(seq_update), .busy(busy), .result(result), .result_valid(result_valid)
  );

  adc_sequencer #(.Madc(5), .T_INIT(1), .T_SAMP(1), .T_COMP(3), .T_UPD(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .continuous(1'b0), .abort(1'b0),
    .comp_out(comp2), .seq_init(s2_init), .seq_samp(s2_samp), .seq_comp(s2_comp),
    .seq_update(s2_upd), .busy(s2_busy), .result(s2_result), .result_valid(s2_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // per-cycle monitor state for the default instance
  int cyc = 0;
  logic [16:0] pat = '0;
  int comp_k, n_comp, n_upd, n_init, n_valid, len_bad, oh_bad, busy_low;
  int first_init;
  int v_cyc [8];
  int len_i = 0, len_s = 0, len_c = 0, len_u = 0;
  logic p_init = 0, p_samp = 0, p_comp = 0, p_upd = 0;

  task automatic clr_stats();
    comp_k = 0; n_comp = 0; n_upd = 0; n_init = 0; n_valid = 0;
    len_bad = 0; first_init = -1;
    for (int i = 0; i < 8; i++) v_cyc[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (seq_init) len_i++; else if (p_init) begin if (len_i != 1) len_bad++; len_i = 0; end
    if (seq_samp) len_s++; else if (p_samp) begin if (len_s != 4) len_bad++; len_s = 0; end
    if (seq_comp) len_c++; else if (p_comp) begin if (len_c != 2) len_bad++; len_c = 0; end
    if (seq_update) len_u++; else if (p_upd) begin if (len_u != 1) len_bad++; len_u = 0; end
    if (seq_init && !p_init) begin
      n_init++;
      comp_k = 0;
      if (first_init < 0) first_init = cyc;
    end
    if (seq_comp && !p_comp) begin
      n_comp++;
      comp_k++;
      if (comp_k <= 17) comp_out = pat[5'(17 - comp_k)];
    end
    if (seq_update && !p_upd) n_upd++;
    if (result_valid) begin
      if (n_valid < 8) v_cyc[n_valid] = cyc;
      n_valid++;
    end
    if ((int'(seq_init) + int'(seq_samp) + int'(seq_comp) + int'(seq_update)) > 1) oh_bad++;
    if ((seq_init | seq_samp | seq_comp | seq_update) && !busy) oh_bad++;
    if (!busy) busy_low++;
    p_init = seq_init; p_samp = seq_samp; p_comp = seq_comp; p_upd = seq_update;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200 && !result_valid; i++) step();
    chk(tag, result_valid, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [4:0] pat2;
  int k2, upd2, init2, vcyc2;
  logic p_c2, p_u2, got2;

  initial begin
    rst = 1'b1; start = 0; continuous = 0; abort = 0; comp_out = 0;
    start2 = 0; comp2 = 0;
    oh_bad = 0; busy_low = 0;
    clr_stats();
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {seq_init, seq_samp, seq_comp, seq_update}, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    step();

    // reset mid-conversion, during the comparison with bc=5
    pat = 17'h1FFFF;
    pulse_start();
    for (int i = 0; i < 200 && !(seq_comp && comp_k == 6); i++) step();
    chk("rst_mid_reach", seq_comp && comp_k == 6, 1);
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_strobes", {seq_init, seq_samp, seq_comp, seq_update}, 0);
    chk("rst_mid_valid", result_valid, 0);
    chk("rst_mid_result", result, 0);
    step();
    chk("rst_mid_idle", busy, 0);

    // single conversion, alternating decisions
    clr_stats();
    pat = 17'h15555;
    pulse_start();
    chk("single_init_first", seq_init, 1);
    wait_valid("single_valid");
    chk("single_result", result, 17'h15555);
    chk("single_latency", v_cyc[0] - first_init, 55);
    step(); step(); step();
    chk("single_nvalid", n_valid, 1);
    chk("single_ncomp", n_comp, 17);
    chk("single_nupd", n_upd, 16);
    chk("single_ninit", n_init, 1);
    chk("single_phase_len", len_bad, 0);
    chk("single_idle", busy, 0);
    chk("single_hold", result, 17'h15555);

    // continuous, three conversions
    clr_stats();
    pat = 17'h1FFFF;
    continuous = 1'b1;
    pulse_start();
    busy_low = 0;
    wait_valid("cont_v1");
    step();
    chk("cont_init1", seq_init, 1);
    wait_valid("cont_v2");
    step();
    chk("cont_init2", seq_init, 1);
    continuous = 1'b0;
    wait_valid("cont_v3");
    chk("cont_result", result, 17'h1FFFF);
    chk("cont_gap1", v_cyc[1] - v_cyc[0], 56);
    chk("cont_gap2", v_cyc[2] - v_cyc[1], 56);
    chk("cont_busy_held", busy_low, 0);
    step();
    chk("cont_stop_busy", busy, 0);
    chk("cont_stop_init", seq_init, 0);

    // abort in DONE: valid still seen, restart suppressed
    pat = 17'h0A5A5;
    continuous = 1'b1;
    pulse_start();
    wait_valid("abdone_valid");
    chk("abdone_result", result, 17'h0A5A5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    continuous = 1'b0;
    chk("abdone_busy", busy, 0);
    chk("abdone_init", seq_init, 0);

    // abort during SAMP
    pat = 17'h1FFFF;
    pulse_start();
    step(); step();
    chk("absamp_reach", seq_samp, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("absamp_busy", busy, 0);
    chk("absamp_strobes", {seq_init, seq_samp, seq_comp, seq_update}, 0);
    chk("absamp_valid", result_valid, 0);
    clr_stats();
    for (int i = 0; i < 80; i++) step();
    chk("absamp_nvalid", n_valid, 0);
    chk("absamp_result", result, 17'h0A5A5);

    // abort during UPD with bc=10
    clr_stats();
    pulse_start();
    for (int i = 0; i < 200 && !(seq_update && comp_k == 11); i++) step();
    chk("abupd_reach", seq_update && comp_k == 11, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abupd_busy", busy, 0);
    chk("abupd_strobes", {seq_init, seq_samp, seq_comp, seq_update}, 0);
    chk("abupd_valid", result_valid, 0);
    for (int i = 0; i < 80; i++) step();
    chk("abupd_nvalid", n_valid, 0);
    chk("abupd_result", result, 17'h0A5A5);

    // abort while idle does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abidle_busy", busy, 0);
    chk("abidle_result", result, 17'h0A5A5);

    // start pulsed during COMP is ignored
    clr_stats();
    pat = 17'h0F0F0;
    pulse_start();
    for (int i = 0; i < 120; i++) begin
      step();
      start = seq_comp && (comp_k == 3);
    end
    start = 1'b0;
    chk("ign_nvalid", n_valid, 1);
    chk("ign_ninit", n_init, 1);
    chk("ign_result", result, 17'h0F0F0);
    chk("ign_idle", busy, 0);
    chk("onehot_busy", oh_bad, 0);

    // override instance: decisions 1,1,0,0,1
    pat2 = 5'b11001;
    k2 = 0; upd2 = 0; vcyc2 = -1; p_c2 = 0; p_u2 = 0; got2 = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    init2 = cyc;
    chk("ovr_init", s2_init, 1);
    for (int i = 0; i < 60; i++) begin
      step();
      if (s2_comp && !p_c2) begin
        k2++;
        if (k2 <= 5) comp2 = pat2[3'(5 - k2)];
      end
      if (s2_upd && !p_u2) upd2++;
      if (s2_valid && !got2) begin
        got2 = 1'b1;
        vcyc2 = cyc;
        chk("ovr_result", s2_result, 5'b11001);
      end
      p_c2 = s2_comp;
      p_u2 = s2_upd;
    end
    chk("ovr_seen", got2, 1);
    chk("ovr_latency", vcyc2 - init2, 25);
    chk("ovr_nupd", upd2, 4);
    chk("ovr_ncomp", k2, 5);
    chk("ovr_idle", s2_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
